// File: rtl/counter_ctrl.sv
// counter_ctrl: count-enable control stage in front of the 64-bit timer counter.
// Runs an IDLE/RUN(/HALT) FSM and a power-of-two prescaler (divide by
// 2^min(div_val,MAX_DIV)), and produces the cnt_en strobe combinationally.
// Build option: define DEBUG_HALT_EN to build the debug HALT state; otherwise
// halt_req is ignored and halt_ack is tied low.
module counter_ctrl #(
  parameter int DIV_W   = 4,
  parameter int PCNT_W  = 8,
  parameter int MAX_DIV = 8
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic             timer_en,
  input  logic             div_en,
  input  logic [DIV_W-1:0] div_val,
  input  logic             presc_clr,
  input  logic             halt_req,
  output logic             cnt_en,
  output logic             halt_ack,
  output logic             run_st
);

`ifdef DEBUG_HALT_EN
  typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;
`else
  typedef enum logic {IDLE, RUN} state_t;
`endif

  state_t            state, state_nxt;
  logic [PCNT_W-1:0] pcnt, pcnt_nxt;
  logic [PCNT_W-1:0] limit;
  logic [DIV_W-1:0]  div_q;
  logic              div_en_q;
  logic [DIV_W-1:0]  div_eff;
  logic              cfg_chg;
  logic              halt_hold;

  // Prescaler terminal count from the live configuration, exponent clamped.
  always_comb begin
    div_eff = (div_val > DIV_W'(MAX_DIV)) ? DIV_W'(MAX_DIV) : div_val;
    limit   = div_en ? PCNT_W'((32'd1 << div_eff) - 32'd1) : '0;
    cfg_chg = (div_val != div_q) | (div_en != div_en_q);
  end

`ifdef DEBUG_HALT_EN
  assign halt_hold = (state == RUN) & halt_req;
  assign halt_ack  = (state == HALT);
`else
  logic unused_halt_req;
  assign unused_halt_req = halt_req;
  assign halt_hold       = 1'b0;
  assign halt_ack        = 1'b0;
`endif

  assign run_st = (state == RUN);

  // Strobe is zero-latency from pcnt; clear and reconfiguration mask it.
  always_comb begin
    cnt_en = (state == RUN) & (pcnt == limit) & ~presc_clr & ~cfg_chg;
  end

  // Next state and next prescaler count.
  always_comb begin
    state_nxt = state;
    pcnt_nxt  = pcnt;
    unique case (state)
      IDLE: if (timer_en) state_nxt = RUN;
      RUN: begin
        if (!timer_en)      state_nxt = IDLE;
`ifdef DEBUG_HALT_EN
        else if (halt_req)  state_nxt = HALT;
      end
      HALT: begin
        if (!timer_en)      state_nxt = IDLE;
        else if (!halt_req) state_nxt = RUN;
`endif
      end
      default: state_nxt = IDLE;
    endcase

    // A config change also clears a held count so pcnt can never sit above a
    // smaller new limit when the FSM resumes from HALT.
    if (presc_clr || cfg_chg || (state == IDLE) || (state_nxt == IDLE))
      pcnt_nxt = '0;
    else if ((state == RUN) && !halt_hold)
      pcnt_nxt = (pcnt == limit) ? '0 : pcnt + PCNT_W'(1);
  end

  // State, prescaler and configuration history registers.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state    <= IDLE;
      pcnt     <= '0;
      div_q    <= '0;
      div_en_q <= 1'b0;
    end else begin
      state    <= state_nxt;
      pcnt     <= pcnt_nxt;
      div_q    <= div_val;
      div_en_q <= div_en;
    end
  end

endmodule
